// File: rtl/pipe_seg_skid.sv
// Valid/ready pipeline segment register with branch-delay-slot tagging and synchronous flush.
// Define PIPE_SEG_SKID_EN to add a one-entry skid buffer so that in_ready is a registered output.
module pipe_seg_skid #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_branch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_bd,
    output logic [1:0]       occupancy
);

    logic             accept;
    logic             pop;
    logic             head_valid;
    logic [WIDTH-1:0] head_data;
    logic             head_bd;
    logic             last_br;

    assign accept    = in_valid & in_ready & resetn & ~flush;
    assign pop       = head_valid & out_ready & ~flush;
    assign out_valid = head_valid;
    assign out_data  = head_data;
    assign out_bd    = head_bd;

    // The payload accepted after a branch is its delay slot.
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            last_br <= 1'b0;
        end else if (accept) begin
            last_br <= in_branch;
        end
    end

`ifdef PIPE_SEG_SKID_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             skid_bd;

    // Registered ready: backpressure never crosses the stage combinationally.
    assign in_ready  = ~skid_valid;
    assign occupancy = {1'b0, head_valid} + {1'b0, skid_valid};

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            head_valid <= 1'b0;
            head_data  <= '0;
            head_bd    <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_bd    <= 1'b0;
        end else if (pop && skid_valid) begin
            head_data  <= skid_data;
            head_bd    <= skid_bd;
            skid_valid <= 1'b0;
        end else if (accept && (!head_valid || pop)) begin
            head_valid <= 1'b1;
            head_data  <= in_data;
            head_bd    <= last_br;
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
            skid_bd    <= last_br;
        end else if (pop) begin
            head_valid <= 1'b0;
        end
    end
`else
    assign in_ready  = ~head_valid | out_ready;
    assign occupancy = {1'b0, head_valid};

    // An accept concurrent with a pop simply replaces the head.
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            head_valid <= 1'b0;
            head_data  <= '0;
            head_bd    <= 1'b0;
        end else if (accept) begin
            head_valid <= 1'b1;
            head_data  <= in_data;
            head_bd    <= last_br;
        end else if (pop) begin
            head_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/pipe_seg_skid.md
# pipe_seg_skid

Parametrised pipeline segment register, the general-purpose successor to the fixed stall/refresh stage registers between CPU pipeline stages. It carries a WIDTH-bit payload between two stages using a valid/ready handshake instead of a global stall, and tags each accepted payload with a branch-delay-slot bit. An optional one-entry skid buffer registers `in_ready` so backpressure never forms a combinational path across the stage. A synchronous flush drops all held entries.

## Interface
- `WIDTH`, 64: payload width in bits; legal range 1..512.
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `flush`  in  1  drop all held entries and clear the branch tracker (the refresh equivalent).
- `in_valid`  in  1  upstream payload valid.
- `in_ready`  out  1  segment can accept this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `in_branch`  in  1  upstream payload is a branch/jump; the next accepted payload is its delay slot.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  downstream consumes the head entry this cycle.
- `out_data`  out  WIDTH  head entry payload.
- `out_bd`  out  1  head entry is a branch delay slot.
- `occupancy`  out  2  number of valid entries, 0..2.

## Operation
- Accept = `in_valid & in_ready & resetn & !flush`. Pop = `out_valid & out_ready & !flush`.
- Storage: head entry (drives the `out_*` ports) and, with the skid buffer, one skid entry. Each entry holds data and a bd bit.
- Branch tracker `last_br`: on accept, the entry's bd bit is set to `last_br`, and `last_br` is updated to `in_branch`. `last_br` is not changed on cycles without an accept.
- Head empty, or head popped with skid empty: an accepted payload loads into the head.
- Head full, no pop: an accepted payload loads into the skid entry.
- Head popped with skid full: the skid entry moves to the head and the skid empties. No accept is possible in this case because `in_ready` is 0.
- Flush: the head and skid are invalidated, `out_data` and `out_bd` are zeroed, and `last_br` is cleared. A concurrent accept is discarded. A concurrent pop does not happen.
- Order is strictly FIFO. No payload is duplicated or dropped except by flush.

## Timing
- Reset (synchronous, `resetn`=0 at a clock edge) gives: `out_valid`=0, `out_data`=0, `out_bd`=0, `occupancy`=0, skid empty, `last_br`=0. With the skid buffer, `in_ready`=1 from the first cycle after reset. Accepts are ignored while `resetn`=0.
- Latency: a payload accepted in cycle N appears on `out_*` in cycle N+1 when the head is empty or being popped.
- With the skid buffer, `in_ready` = !skid_valid, a pure register output. It never depends on `out_ready` in the same cycle.
- Full throughput: one accept and one pop per cycle is sustained with `occupancy`=1.
- `out_valid`, `out_data`, and `out_bd` are register outputs and are stable while `out_ready`=0.
- Flush takes priority over accept and pop. After a flush cycle, `occupancy`=0 and `in_ready`=1.
- `resetn` low during operation discards entries identically to flush and takes priority over it.

## Configuration
- `PIPE_SEG_SKID_EN` defined: two-entry operation as described above, with `in_ready` registered and `occupancy` ranging 0..2.
- `PIPE_SEG_SKID_EN` undefined: no skid entry. `in_ready` = !out_valid | out_ready, which is combinational. An accept with a simultaneous pop replaces the head. `occupancy` ranges 0..1 and its bit 1 is tied to 0. Bd tagging, flush, and reset behaviour are unchanged.

## Test plan
- Reset, then `in_valid`=1 with `in_data`=0x11, `out_ready`=1 -> next cycle `out_valid`=1, `out_data`=0x11, `out_bd`=0, `occupancy`=1.
- Stream 0x1,0x2,0x3 with `in_branch` on 0x2 only, `out_ready`=1 -> outputs 0x1/bd0, 0x2/bd0, 0x3/bd1 on consecutive cycles.
- With `out_ready`=0, push 0xA then 0xB (skid build) -> `occupancy`=2, `in_ready`=0, head 0xA. Raise `out_ready` -> 0xA then 0xB appear, and `in_ready` returns to 1 the cycle after 0xA pops.
- Hold two entries and assert `flush` together with `in_valid`=1 (0xC) -> next cycle `out_valid`=0, `out_data`=0, `occupancy`=0, and 0xC is not delivered.
- Accept a branch (0x5), `flush`, then accept 0x6 -> 0x6 is delivered with `out_bd`=0.
- Drive `resetn`=0 mid-stream with `occupancy`=2 -> all outputs return to reset values on the next edge. Random valid/ready traffic afterwards matches a FIFO scoreboard.
